// File: rtl/dispenser_sequencer.sv
// dispenser_sequencer: motor/pump run sequencer for the colour dispenser.
//
// Purpose: latches N_CH programmed cycle counts on a start pulse and drives one
// motor output per channel for count * TICK_DIV clock cycles. Channels run one
// at a time (lowest index first) or all together. Per-channel completion flags
// are reported.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   start      single-cycle start pulse (already synchronised)
//   abort      stop immediately (level or pulse), priority over start
//   parallel   mode sampled on accepted start: 0 sequential, 1 simultaneous
//   ciclos     channel i count in bits [i*CNT_W +: CNT_W]
//   motores    motor enables, bit i = channel i
//   ch_done    sticky per-channel completion flags
//   busy       run in progress
//   done       one-cycle pulse on normal completion
//   remaining  ticks left on lowest-index running channel, 0 when idle
//
// Configuration macro: DISPENSER_GAP_EN -- when defined, sequential runs insert
// one full tick period with all motors off between consecutive channels.

module dispenser_sequencer #(
    parameter int unsigned N_CH     = 3,
    parameter int unsigned CNT_W    = 5,
    parameter int unsigned TICK_DIV = 20000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  parallel,
    input  logic [N_CH*CNT_W-1:0] ciclos,
    output logic [N_CH-1:0]       motores,
    output logic [N_CH-1:0]       ch_done,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      remaining
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TickLast = PW'(TICK_DIV - 1);

`ifdef DISPENSER_GAP_EN
    typedef enum logic [1:0] {StIdle, StSeq, StPar, StGap} state_t;
`else
    typedef enum logic [1:0] {StIdle, StSeq, StPar} state_t;
`endif

    state_t           r_state, w_state_d;
    logic [CNT_W-1:0] r_cnt [N_CH];
    logic [CNT_W-1:0] w_cnt_d [N_CH];
    logic [PW-1:0]    r_presc, w_presc_d;
    logic [N_CH-1:0]  r_motores, w_motores_d;
    logic [N_CH-1:0]  r_ch_done, w_ch_done_d;
    logic             r_busy;
    logic             r_done, w_done_d;
    logic [CNT_W-1:0] r_remaining, w_remaining_d;

    logic             w_tick;
    logic [N_CH-1:0]  w_nz;      // channels with a nonzero latched count
    logic [N_CH-1:0]  w_last;    // channels whose count is exactly 1
    logic [N_CH-1:0]  w_act_oh;  // lowest-index nonzero channel, one-hot
    logic [N_CH-1:0]  w_nz_d;
    logic [N_CH-1:0]  w_low_d;

    assign w_tick = (r_presc == TickLast);

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_nz[i]   = (r_cnt[i] != '0);
            w_last[i] = (r_cnt[i] == CNT_W'(1));
        end
        // x & -x isolates the lowest set bit
        w_act_oh = w_nz & (~w_nz + N_CH'(1));
    end

    // Next-state logic
    always_comb begin
        w_state_d   = r_state;
        w_presc_d   = '0;
        w_ch_done_d = r_ch_done;
        w_done_d    = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            w_cnt_d[i] = r_cnt[i];
        end

        case (r_state)
            StIdle: begin
                if (start) begin
                    for (int i = 0; i < N_CH; i++) begin
                        w_cnt_d[i]     = ciclos[i*CNT_W +: CNT_W];
                        w_ch_done_d[i] = (ciclos[i*CNT_W +: CNT_W] == '0);
                    end
                    if (ciclos == '0) begin
                        // Nothing to dispense: complete at once without going busy
                        w_done_d = 1'b1;
                    end else if (parallel) begin
                        w_state_d = StPar;
                    end else begin
                        w_state_d = StSeq;
                    end
                end
            end

            StSeq: begin
                w_presc_d = w_tick ? '0 : r_presc + PW'(1);
                if (w_tick) begin
                    for (int i = 0; i < N_CH; i++) begin
                        if (w_act_oh[i]) begin
                            w_cnt_d[i] = r_cnt[i] - CNT_W'(1);
                        end
                    end
                    if ((w_act_oh & w_last) != '0) begin
                        w_ch_done_d = r_ch_done | w_act_oh;
                        if (w_nz == w_act_oh) begin
                            w_state_d = StIdle;
                            w_done_d  = 1'b1;
                        end else begin
`ifdef DISPENSER_GAP_EN
                            w_state_d = StGap;
`else
                            w_state_d = StSeq;
`endif
                        end
                    end
                end
            end

            StPar: begin
                w_presc_d = w_tick ? '0 : r_presc + PW'(1);
                if (w_tick) begin
                    for (int i = 0; i < N_CH; i++) begin
                        if (w_nz[i]) begin
                            w_cnt_d[i] = r_cnt[i] - CNT_W'(1);
                        end
                    end
                    w_ch_done_d = r_ch_done | w_last;
                    if ((w_nz & ~w_last) == '0) begin
                        w_state_d = StIdle;
                        w_done_d  = 1'b1;
                    end
                end
            end

`ifdef DISPENSER_GAP_EN
            StGap: begin
                w_presc_d = w_tick ? '0 : r_presc + PW'(1);
                if (w_tick) begin
                    w_state_d = StSeq;
                end
            end
`endif

            default: begin
                w_state_d = StIdle;
            end
        endcase

        // Abort wins everywhere: drop the run, keep completion flags
        if (abort) begin
            w_state_d   = StIdle;
            w_presc_d   = '0;
            w_ch_done_d = r_ch_done;
            w_done_d    = 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                w_cnt_d[i] = '0;
            end
        end
    end

    // Registered outputs are derived from the next-state counts
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_nz_d[i] = (w_cnt_d[i] != '0);
        end
        w_low_d       = w_nz_d & (~w_nz_d + N_CH'(1));
        w_motores_d   = '0;
        w_remaining_d = '0;
        if (w_state_d == StSeq) begin
            w_motores_d = w_low_d;
        end else if (w_state_d == StPar) begin
            w_motores_d = w_nz_d;
        end
        if (w_state_d == StSeq || w_state_d == StPar) begin
            for (int i = 0; i < N_CH; i++) begin
                if (w_low_d[i]) begin
                    w_remaining_d = w_cnt_d[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_presc     <= '0;
            r_motores   <= '0;
            r_ch_done   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_remaining <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_state     <= w_state_d;
            r_presc     <= w_presc_d;
            r_motores   <= w_motores_d;
            r_ch_done   <= w_ch_done_d;
            r_busy      <= (w_state_d != StIdle);
            r_done      <= w_done_d;
            r_remaining <= w_remaining_d;
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i] <= w_cnt_d[i];
            end
        end
    end

    assign motores   = r_motores;
    assign ch_done   = r_ch_done;
    assign busy      = r_busy;
    assign done      = r_done;
    assign remaining = r_remaining;

endmodule

// File: doc/dispenser_sequencer.md
# dispenser_sequencer

Parametrised motor/pump run sequencer for the colour dispenser, generalising the fixed three-channel RGB timer plus motor FSM. It latches N_CH programmed cycle counts on a start pulse and drives one motor output per channel for count × TICK_DIV clock cycles, either one channel at a time or all channels together. It sits between the keypad/memory front end (which supplies counts and the synchronised enter pulse) and the motor pins, and reports per-channel completion flags.

## Interface

Parameters:
- N_CH, 3, number of channels/motors (≥1)
- CNT_W, 5, width of each channel cycle count
- TICK_DIV, 20000000, clock cycles per dispense tick (≥2)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle start pulse (already synchronised enter)
- abort  in  1  stop immediately, level or pulse
- parallel  in  1  mode, sampled on accepted start: 0 sequential, 1 simultaneous
- ciclos  in  N_CH*CNT_W  channel i count in bits [i*CNT_W +: CNT_W]
- motores  out  N_CH  motor enables, bit i = channel i
- ch_done  out  N_CH  sticky per-channel completion flags
- busy  out  1  run in progress
- done  out  1  one-cycle pulse on normal completion
- remaining  out  CNT_W  ticks left on lowest-index running channel, 0 when idle

## Operation

- States: IDLE, SEQ, PAR, GAP (GAP only with macro).
- IDLE: start=1 and abort=0 → latch all counts and mode; ch_done ← mask of zero-count channels; prescaler ← 0. Next state SEQ or PAR. All-zero counts → stay IDLE, done pulses, busy stays 0.
- start while busy ignored. abort has priority over start in every state.
- Prescaler free-runs 0..TICK_DIV-1 while busy; tick = prescaler==TICK_DIV-1.
- SEQ: active channel = lowest-index nonzero count; its motor on, others off. Each tick decrements active count; on 1→0: set its ch_done bit, move to next-higher nonzero channel (motor handover in same cycle, no overlap). No channel left → IDLE.
- PAR: every nonzero channel on; each decrements per tick; channel reaching 0 turns off and sets ch_done. All zero → IDLE.
- Leaving to IDLE normally: done=1 for that one cycle, busy=0, motores=0.
- abort: next cycle motores=0, busy=0, state IDLE, no done pulse, ch_done retained, latched counts discarded.
- remaining: latched count of lowest-index running channel; 0 in IDLE/GAP.
- Count of 0 never energises its motor.

## Timing

- Reset values: motores=0, ch_done=0, busy=0, done=0, remaining=0, state IDLE, prescaler 0.
- All outputs registered. Start accepted in cycle t → busy and first motor(s) high at t+1; first tick at cycle t+TICK_DIV; subsequent ticks every TICK_DIV cycles.
- Channel with count k is on exactly k*TICK_DIV cycles; output changes appear the cycle after the tick.
- done and busy-fall occur in the same cycle, the cycle after the final tick.
- Reset mid-run clears all outputs asynchronously, without waiting for a clock edge.

## Configuration

- DISPENSER_GAP_EN defined: in SEQ, after a channel finishes (and another remains), enter GAP with all motors off for one full tick period, then start next channel on the cycle after that tick. No gap after the last channel; PAR unaffected.
- Undefined: GAP state absent, seamless handover as above.

## Test plan

- TICK_DIV=4, counts ch0=2, ch1=0, ch2=3, sequential, start at cycle 0 → motores=3'b001 cycles 1–8, 3'b100 cycles 9–20, done and busy=0 at 21, ch_done=3'b010 at 1, 3'b011 at 9, 3'b111 at 21.
- Same with DISPENSER_GAP_EN → 3'b001 cycles 1–8, 3'b000 cycles 9–12, 3'b100 cycles 13–24, done at 25.
- Same counts, parallel=1 → 3'b101 cycles 1–8, 3'b100 cycles 9–12, done at 13.
- Sequential run, abort at cycle 5 → motores=0 and busy=0 from cycle 6, no done, ch_done=3'b010; later start runs normally.
- All counts 0, start → done at cycle 1, busy never high, ch_done=3'b111; start+abort together in IDLE → no activity.
- Start during run ignored (outputs match undisturbed run); reset asserted mid-run → all outputs 0 immediately, idle after release.
